mem_phase_scheduler: RTL and testbench
======================================

// Module: mem_phase_scheduler
// PURPOSE
//  Owns the single-port data memory and sequences its use across phases: LOAD (UART collector
//  writes input bytes), RUN (systolic feeder reads and result writer writes, arbitrated), DONE.
//  Sits between the UART collector, the array feeder/result path, and the block RAM.
// PARAMETERS
//  ADDR_W    14     memory address width
//  DATA_W    8      memory data width
//  NUM_DATA  2500   input bytes accepted in LOAD before moving to RUN
//  NUM_RES   2500   result writes accepted in RUN before moving to DONE
//  RES_BASE  5000   base address of result region; res_addr is an offset from it
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  start         in   1       one-cycle pulse; IDLE -> LOAD
//  col_we        in   1       collector write strobe (one cycle per byte, cannot stall)
//  col_addr      in   ADDR_W  collector write address
//  col_data      in   DATA_W  collector write data
//  rd_req        in   1       feeder read request, held until rd_gnt
//  rd_addr       in   ADDR_W  feeder read address
//  rd_gnt        out  1       feeder grant (combinational)
//  rd_valid      out  1       rd_data valid
//  rd_data       out  DATA_W  read data (pass-through of mem_rdata)
//  res_req       in   1       result write request, held until res_gnt
//  res_addr      in   ADDR_W  result offset
//  res_data      in   DATA_W  result data
//  res_gnt       out  1       result grant (combinational)
//  mem_en/mem_we out  1 each  memory enable / write enable (registered)
//  mem_addr      out  ADDR_W  memory address (registered)
//  mem_wdata     out  DATA_W  memory write data (registered)
//  mem_rdata     in   DATA_W  memory read data, one cycle after mem_en
//  phase         out  2       IDLE=0 LOAD=1 RUN=2 DONE=3
//  done          out  1       high for exactly the one cycle in DONE
//  err_overrun   out  1       sticky overrun flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: phase=IDLE; mem_en/mem_we=0, mem_addr/mem_wdata=0; rd_valid=0, done=0,
//    err_overrun=0; load/result counters and RR pointer cleared; in-flight read discarded.
//  - IDLE: start -> LOAD next cycle. col_we in IDLE is accepted (writes memory, not counted).
//  - LOAD: each col_we -> mem_we=1, mem_addr=col_addr, mem_wdata=col_data next cycle;
//    load count increments; write with count==NUM_DATA-1 moves to RUN next cycle.
//    rd_gnt/res_gnt held 0.
//  - RUN: at most one access per cycle. Grant = 2-way round-robin over {rd_req,res_req};
//    pointer favours the requester not granted last; a lone requester is granted every cycle.
//    Read grant in cycle N: mem_en=1,mem_we=0 in N+1; rd_valid=1 in N+2.
//    Result grant: mem_addr=(RES_BASE+res_addr) mod 2^ADDR_W, mem_we=1 in N+1;
//    result count increments; grant with count==NUM_RES-1 moves to DONE next cycle.
//  - col_we in RUN/DONE: dropped (no memory access), never blocks arbitration.
//  - DONE: done=1 one cycle, then IDLE; counters clear. start ignored outside IDLE.
//  - Idle cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last value.
//  - rst mid-RUN with read in flight: rd_valid is not asserted for it.
// CONFIGURATION
//  MEM_SCHED_OVERRUN_CHK_EN defined: col_we in RUN or DONE sets err_overrun, held until rst.
//  Undefined: err_overrun tied 0; dropped writes are silent. Arbitration identical in both.
// STRUCTURE
//  Package systolic_pkg: phase_t enum (IDLE/LOAD/RUN/DONE), ADDR_W/DATA_W defaults,
//  mem request struct {we, addr, wdata}.
//  Sub-module rr_arb2: 2-requester round-robin arbiter with last-grant pointer, reset to
//  favour rd. Phase FSM, counters and memory-port register stay in the top.
// TESTING
//  1 rst then start, 2500 col_we pulses (addr 0..2499, data=addr[7:0]) -> 2500 mem writes,
//    phase=RUN the cycle after the last write.
//  2 RUN, rd_req alone at addr 7 -> rd_gnt same cycle, mem_en/we=1/0 next cycle,
//    rd_valid 2 cycles after grant with data 8'd7.
//  3 RUN, rd_req and res_req both held 6 cycles -> grants alternate, starting rd;
//    each res write lands at 5000+offset.
//  4 RUN, res_addr=14'h3FFF with RES_BASE=5000 -> mem_addr=4999 (wrap).
//  5 2500th result grant -> DONE one cycle, done pulse, then IDLE; next start -> LOAD.
//  6 col_we in RUN -> no mem write; err_overrun=1 only with MEM_SCHED_OVERRUN_CHK_EN;
//    rst mid-RUN with read in flight -> no rd_valid, all outputs at reset values.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic memory path: phase encoding, default widths
// and the single-port memory request record.
package systolic_pkg;

    localparam int SYS_ADDR_W = 14;
    localparam int SYS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } phase_t;

    typedef struct packed {
        logic                  we;
        logic [SYS_ADDR_W-1:0] addr;
        logic [SYS_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (feeder read vs result write).
// The pointer remembers whether the last grant went to the reader; on a tie
// the other requester wins. Out of reset the reader is favoured.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_rd,
    input  logic req_res,
    output logic gnt_rd,
    output logic gnt_res
);

    logic last_rd;

    // Grant decode: a lone requester always wins, a tie goes to the one not served last
    always_comb begin
        gnt_rd  = en && req_rd  && (!req_res || !last_rd);
        gnt_res = en && req_res && (!req_rd  ||  last_rd);
    end

    // Last-grant pointer, only moves when something is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd <= 1'b0;
        end else if (gnt_rd) begin
            last_rd <= 1'b1;
        end else if (gnt_res) begin
            last_rd <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_phase_scheduler.sv
// Phase sequencer and owner of the single-port data memory.
// IDLE -> LOAD (collector fills memory) -> RUN (feeder reads / result writes,
// round-robin arbitrated, one access per cycle) -> DONE (one cycle) -> IDLE.
// Optional build macro MEM_SCHED_OVERRUN_CHK_EN: collector writes arriving in
// RUN or DONE raise a sticky err_overrun; without it they are dropped silently.
module mem_phase_scheduler
    import systolic_pkg::*;
#(
    parameter int ADDR_W   = SYS_ADDR_W,
    parameter int DATA_W   = SYS_DATA_W,
    parameter int NUM_DATA = 2500,
    parameter int NUM_RES  = 2500,
    parameter int RES_BASE = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_we,
    input  logic [ADDR_W-1:0] col_addr,
    input  logic [DATA_W-1:0] col_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              res_req,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        phase,
    output logic              done,
    output logic              err_overrun
);

    localparam int LD_W = $clog2(NUM_DATA + 1);
    localparam int RS_W = $clog2(NUM_RES + 1);

    phase_t            phase_q, phase_d;
    logic [LD_W-1:0]   ld_cnt;
    logic [RS_W-1:0]   rs_cnt;
    logic              col_ok;
    logic              ld_last;
    logic              rs_last;
    logic [ADDR_W-1:0] res_mem_addr;
    mem_req_t          req;
    logic              req_en;
    logic              rd_vld_p1;
    logic              rd_vld_p2;

    // Collector writes land in memory only before RUN; result offsets wrap in the address space
    assign col_ok       = col_we && ((phase_q == IDLE) || (phase_q == LOAD));
    assign ld_last      = (phase_q == LOAD) && col_we && (ld_cnt == LD_W'(NUM_DATA - 1));
    assign rs_last      = res_gnt && (rs_cnt == RS_W'(NUM_RES - 1));
    assign res_mem_addr = ADDR_W'(RES_BASE) + res_addr;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (phase_q == RUN),
        .req_rd  (rd_req),
        .req_res (res_req),
        .gnt_rd  (rd_gnt),
        .gnt_res (res_gnt)
    );

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase transitions and the one-cycle done pulse
    always_comb begin
        phase_d = phase_q;
        done    = 1'b0;
        case (phase_q)
            IDLE: if (start) phase_d = LOAD;
            LOAD: if (ld_last) phase_d = RUN;
            RUN:  if (rs_last) phase_d = DONE;
            DONE: begin
                phase_d = IDLE;
                done    = 1'b1;
            end
            default: phase_d = IDLE;
        endcase
    end

    // Load and result counters; wrap to zero on the last item and clear in DONE
    always_ff @(posedge clk) begin
        if (rst || (phase_q == DONE)) begin
            ld_cnt <= '0;
            rs_cnt <= '0;
        end else begin
            if ((phase_q == LOAD) && col_we) begin
                ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
            end
            if (res_gnt) begin
                rs_cnt <= rs_last ? '0 : rs_cnt + 1'b1;
            end
        end
    end

    // Select this cycle's memory access; address and data hold when nothing is issued
    always_comb begin
        req_en    = 1'b0;
        req.we    = 1'b0;
        req.addr  = mem_addr;
        req.wdata = mem_wdata;
        if (col_ok) begin
            req_en    = 1'b1;
            req.we    = 1'b1;
            req.addr  = col_addr;
            req.wdata = col_data;
        end else if (rd_gnt) begin
            req_en   = 1'b1;
            req.addr = rd_addr;
        end else if (res_gnt) begin
            req_en    = 1'b1;
            req.we    = 1'b1;
            req.addr  = res_mem_addr;
            req.wdata = res_data;
        end
    end

    // Registered memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= req_en;
            mem_we    <= req.we;
            mem_addr  <= req.addr;
            mem_wdata <= req.wdata;
        end
    end

    // Stage p1: read issued to memory; stage p2: memory data returned
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            rd_vld_p2 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_gnt;
            rd_vld_p2 <= rd_vld_p1;
        end
    end

    assign rd_valid = rd_vld_p2;
    assign rd_data  = mem_rdata;
    assign phase    = phase_q;

`ifdef MEM_SCHED_OVERRUN_CHK_EN
    logic err_q;

    // Sticky flag for collector bytes that arrive after loading has finished
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (col_we && ((phase_q == RUN) || (phase_q == DONE))) begin
            err_q <= 1'b1;
        end
    end

    assign err_overrun = err_q;
`else
    assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mem_phase_scheduler.sv
// Self-checking bench for mem_phase_scheduler with a behavioural phase /
// arbitration / memory model and a simple block-RAM model on the memory port.
module tb_mem_phase_scheduler;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int NUM_DATA  = 2500;
    localparam int NUM_RES   = 2500;
    localparam int RES_BASE  = 5000;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, col_we, rd_req, res_req;
    logic [ADDR_W-1:0] col_addr, rd_addr, res_addr;
    logic [DATA_W-1:0] col_data, res_data;
    logic              rd_gnt, rd_valid, res_gnt, mem_en, mem_we, done, err_overrun;
    logic [DATA_W-1:0] rd_data, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        phase;

    always #5 clk = ~clk;

    mem_phase_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
        .NUM_RES(NUM_RES), .RES_BASE(RES_BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .col_we(col_we), .col_addr(col_addr), .col_data(col_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .res_req(res_req), .res_addr(res_addr), .res_data(res_data), .res_gnt(res_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .phase(phase), .done(done), .err_overrun(err_overrun)
    );

    // Block RAM attached to the memory port: one-cycle read latency
    logic [DATA_W-1:0] bram [MEM_DEPTH];
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= bram[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: phase as 0..3, item counts, who was served last,
    // expected memory port, and a list of future cycles where read data is due
    int                m_phase, m_ld, m_rs, cyc;
    bit                m_last_rd, m_en, m_we, m_err, last_g_rd, last_g_res;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    int                vq_cyc[$];
    logic [DATA_W-1:0] vq_dat[$];

    // Held requests (feeder and result writer keep req high until granted)
    bit                p_rd, p_res;
    logic [ADDR_W-1:0] p_rd_addr, p_res_off;
    logic [DATA_W-1:0] p_res_dat;

    task automatic model_reset();
        m_phase = 0; m_ld = 0; m_rs = 0; m_last_rd = 1'b0;
        m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_err = 1'b0;
        vq_cyc.delete(); vq_dat.delete();
    endtask

    // One clock cycle: inputs already set at the falling edge
    task automatic tick();
        bit g_rd, g_res, exp_v;
        int nph;
        #1;
        g_rd  = 1'b0;
        g_res = 1'b0;
        if (m_phase == 2) begin
            g_rd  = rd_req && (!res_req || !m_last_rd);
            g_res = res_req && !g_rd;
        end
        if (!rst) begin
            chk("rd_gnt", rd_gnt, g_rd);
            chk("res_gnt", res_gnt, g_res);
        end
        last_g_rd  = g_rd && !rst;
        last_g_res = g_res && !rst;
        if (rst) begin
            model_reset();
        end else begin
            m_en = 1'b0;
            m_we = 1'b0;
            if (col_we && (m_phase <= 1)) begin
                m_en = 1'b1; m_we = 1'b1; m_addr = col_addr; m_wdata = col_data;
                ref_mem[col_addr] = col_data;
            end else if (g_rd) begin
                m_en = 1'b1; m_addr = rd_addr;
                vq_cyc.push_back(cyc + 2);
                vq_dat.push_back(ref_mem[rd_addr]);
            end else if (g_res) begin
                m_en = 1'b1; m_we = 1'b1;
                m_addr = ADDR_W'((RES_BASE + int'(res_addr)) % MEM_DEPTH);
                m_wdata = res_data;
                ref_mem[m_addr] = res_data;
            end
            if (g_rd) m_last_rd = 1'b1;
            else if (g_res) m_last_rd = 1'b0;
`ifdef MEM_SCHED_OVERRUN_CHK_EN
            if (col_we && (m_phase >= 2)) m_err = 1'b1;
`endif
            nph = m_phase;
            case (m_phase)
                0: if (start) nph = 1;
                1: if (col_we) begin
                    m_ld++;
                    if (m_ld == NUM_DATA) begin m_ld = 0; nph = 2; end
                end
                2: if (g_res) begin
                    m_rs++;
                    if (m_rs == NUM_RES) begin m_rs = 0; nph = 3; end
                end
                default: nph = 0;
            endcase
            m_phase = nph;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("phase", phase, m_phase);
        chk("done", done, m_phase == 3);
        chk("mem_en", mem_en, m_en);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("err_overrun", err_overrun, m_err);
        exp_v = (vq_cyc.size() > 0) && (vq_cyc[0] == cyc);
        chk("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            chk("rd_data", rd_data, vq_dat[0]);
            void'(vq_cyc.pop_front());
            void'(vq_dat.pop_front());
        end
        @(negedge clk);
    endtask

    // Retire granted requests and randomly raise new ones
    task automatic drive_req();
        if (last_g_rd) p_rd = 1'b0;
        if (last_g_res) p_res = 1'b0;
        if (!p_rd && ($urandom_range(0, 1) == 1)) begin
            p_rd = 1'b1;
            p_rd_addr = ADDR_W'($urandom_range(0, NUM_DATA - 1));
        end
        if (!p_res && ($urandom_range(0, 1) == 1)) begin
            p_res = 1'b1;
            p_res_off = ADDR_W'($urandom_range(0, NUM_RES - 1));
            p_res_dat = DATA_W'($urandom);
        end
        rd_req = p_rd; rd_addr = p_rd_addr;
        res_req = p_res; res_addr = p_res_off; res_data = p_res_dat;
    endtask

    task automatic idle_inputs();
        start = 1'b0; col_we = 1'b0; rd_req = 1'b0; res_req = 1'b0;
        p_rd = 1'b0; p_res = 1'b0; last_g_rd = 1'b0; last_g_res = 1'b0;
    endtask

    task automatic load_all(input bit rand_data);
        for (int i = 0; i < NUM_DATA; i++) begin
            while ($urandom_range(0, 7) == 0) begin
                col_we = 1'b0;
                start  = $urandom_range(0, 1) == 1;
                tick();
            end
            start    = 1'b0;
            col_we   = 1'b1;
            col_addr = ADDR_W'(i);
            col_data = rand_data ? DATA_W'($urandom) : DATA_W'(i);
            tick();
        end
        col_we = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; col_addr = '0; col_data = '0; rd_addr = '0; res_addr = '0; res_data = '0;
        p_rd_addr = '0; p_res_off = '0; p_res_dat = '0; cyc = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Collector write while idle is stored but does not start loading
        col_we = 1'b1; col_addr = 14'd3000; col_data = 8'hA5;
        tick();
        col_we = 1'b0;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        load_all(1'b0);
        chk("phase_after_load", phase, 2);

        // Lone read of address 7, then of the idle-phase write
        rd_req = 1'b1; rd_addr = 14'd7;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        rd_req = 1'b1; rd_addr = 14'd3000;
        tick();
        rd_req = 1'b0;
        tick();
        chk("rd_3000_data", rd_data, 8'hA5);
        tick();

        // Result offset that wraps the address space
        res_req = 1'b1; res_addr = 14'h3FFF; res_data = 8'h5C;
        tick();
        res_req = 1'b0;
        chk("wrap_addr", mem_addr, 4999);

        // Both requesters held for six cycles
        rd_req = 1'b1; rd_addr = 14'd100; res_req = 1'b1; res_addr = 14'd10; res_data = 8'h3C;
        for (int k = 0; k < 6; k++) begin
            res_addr = ADDR_W'(10 + k);
            tick();
        end
        rd_req = 1'b0; res_req = 1'b0;

        // Collector byte arriving during RUN must be dropped
        col_we = 1'b1; col_addr = 14'd20; col_data = 8'hEE;
        tick();
        col_we = 1'b0;

        // Random traffic until the last result is accepted
        guard = 0;
        while ((m_phase == 2) && (guard < 20000)) begin
            drive_req();
            col_we   = $urandom_range(0, 31) == 0;
            col_addr = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
            col_data = DATA_W'($urandom);
            tick();
            guard++;
        end
        idle_inputs();
        chk("run_reached_done", phase, 3);
        chk("done_pulse", done, 1);
        tick();
        chk("back_to_idle", phase, 0);

        // Second job: start ignored outside IDLE is exercised during loading
        start = 1'b1;
        tick();
        start = 1'b0;
        load_all(1'b1);
        rd_req = 1'b1; rd_addr = ADDR_W'($urandom_range(0, NUM_DATA - 1));
        tick();
        rd_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("no_valid_after_rst", rd_valid, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
